pipe_hazard_ctrl: RTL

- Central pipeline control unit; produces the stall/bubble controls consumed by the F, D, E, M and W pipeline registers.
- Detects load-use hazards, branch redirects, data-memory wait and fetch wait.
- Sequences serializing instructions (fence/CSR/ecall) with a drain state machine.
- Keeps stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline hazard controller signal bundle
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             decode_i_valid;
  logic [4:0]       decode_i_rs1;
  logic [4:0]       decode_i_rs2;
  logic             decode_i_rs1_ren;
  logic             decode_i_rs2_ren;
  logic             decode_i_serialize;
  logic [4:0]       regE_i_rd;
  logic             regE_i_reg_wen;
  logic             regE_i_is_load;
  logic             execute_i_redirect;
  logic             regM_i_mem_valid;
  logic             dmem_i_ready;
  logic             ifu_i_valid;
  logic             regF_o_stall;
  logic             regD_o_stall;
  logic             regD_o_bubble;
  logic             regE_o_stall;
  logic             regE_o_bubble;
  logic             regM_o_stall;
  logic             regW_o_bubble;
  logic [1:0]       ctrl_o_state;
  logic [CNT_W-1:0] ctrl_o_stall_cycles;
  logic [CNT_W-1:0] ctrl_o_flush_count;

  modport master (
    output decode_i_valid, decode_i_rs1, decode_i_rs2, decode_i_rs1_ren, decode_i_rs2_ren,
           decode_i_serialize, regE_i_rd, regE_i_reg_wen, regE_i_is_load, execute_i_redirect,
           regM_i_mem_valid, dmem_i_ready, ifu_i_valid,
    input  regF_o_stall, regD_o_stall, regD_o_bubble, regE_o_stall, regE_o_bubble,
           regM_o_stall, regW_o_bubble, ctrl_o_state, ctrl_o_stall_cycles, ctrl_o_flush_count
  );

  modport slave (
    input  decode_i_valid, decode_i_rs1, decode_i_rs2, decode_i_rs1_ren, decode_i_rs2_ren,
           decode_i_serialize, regE_i_rd, regE_i_reg_wen, regE_i_is_load, execute_i_redirect,
           regM_i_mem_valid, dmem_i_ready, ifu_i_valid,
    output regF_o_stall, regD_o_stall, regD_o_bubble, regE_o_stall, regE_o_bubble,
           regM_o_stall, regW_o_bubble, ctrl_o_state, ctrl_o_stall_cycles, ctrl_o_flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/bubble control with serialize drain FSM
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mem_wait, redirect, load_use, ser_start, fetch_wait;
  logic rs1_hit, rs2_hit;
  logic f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, w_bubble;
  logic redirect_taken;

  assign mem_wait   = bus.regM_i_mem_valid & ~bus.dmem_i_ready;
  assign redirect   = bus.execute_i_redirect;
  assign rs1_hit    = bus.decode_i_rs1_ren & (bus.decode_i_rs1 == bus.regE_i_rd);
  assign rs2_hit    = bus.decode_i_rs2_ren & (bus.decode_i_rs2 == bus.regE_i_rd);
  assign load_use   = bus.regE_i_is_load & bus.regE_i_reg_wen & (bus.regE_i_rd != 5'd0) &
                      bus.decode_i_valid & (rs1_hit | rs2_hit);
  assign ser_start  = bus.decode_i_valid & bus.decode_i_serialize;
  assign fetch_wait = ~bus.ifu_i_valid;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    f_stall        = 1'b0;
    d_stall        = 1'b0;
    d_bubble       = 1'b0;
    e_stall        = 1'b0;
    e_bubble       = 1'b0;
    m_stall        = 1'b0;
    w_bubble       = 1'b0;
    redirect_taken = 1'b0;
    if (mem_wait) begin
      // Whole pipe frozen; redirect/serialize are seen again once E is released.
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_stall  = 1'b1;
      w_bubble = 1'b1;
    end else if (redirect) begin
      d_bubble       = 1'b1;
      e_bubble       = 1'b1;
      redirect_taken = 1'b1;
      state_d        = ST_RUN;
      cnt_d          = 4'd0;
    end else if (state_q == ST_DRAIN) begin
      if (cnt_q > 4'd1) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        e_bubble = 1'b1;
        cnt_d    = cnt_q - 4'd1;
      end else begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    end else if (load_use) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_bubble = 1'b1;
    end else if (ser_start) begin
      // Entry cycle is the first of the DRAIN_CYCLES bubbles.
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_bubble = 1'b1;
      state_d  = ST_DRAIN;
      cnt_d    = 4'(DRAIN_CYCLES);
    end else if (fetch_wait) begin
      f_stall  = 1'b1;
      d_bubble = 1'b1;
    end
  end

  assign bus.regF_o_stall  = f_stall  & rst;
  assign bus.regD_o_stall  = d_stall  & rst;
  assign bus.regD_o_bubble = d_bubble & rst;
  assign bus.regE_o_stall  = e_stall  & rst;
  assign bus.regE_o_bubble = e_bubble & rst;
  assign bus.regM_o_stall  = m_stall  & rst;
  assign bus.regW_o_bubble = w_bubble & rst;

  assign stall_cyc_d = f_stall ? stall_cyc_q + CNT_W'(1) : stall_cyc_q;
  assign flush_d     = redirect_taken ? flush_q + CNT_W'(1) : flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      stall_cyc_q <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cyc_q <= stall_cyc_d;
      flush_q     <= flush_d;
    end
  end

  assign bus.ctrl_o_state        = state_q;
  assign bus.ctrl_o_stall_cycles = stall_cyc_q;
  assign bus.ctrl_o_flush_count  = flush_q;

endmodule
